// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter: shares one sdram_controller user port between requesters A and B,
// one outstanding op at a time, read data routed back to the issuing port.
module sdram_req_arbiter #(
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 32,
  parameter int PRIO_A     = 0,
  parameter int STARVE_MAX = 4,
  parameter int RD_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_rw,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_rw,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ctl_in_valid,
  output logic              ctl_rw,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [DATA_W-1:0] ctl_wdata,
  input  logic              ctl_busy,
  input  logic              ctl_out_valid,
  input  logic [DATA_W-1:0] ctl_rdata,
  output logic              err_timeout
);
  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, WAIT_RD} state_t;
  state_t state, state_n;
  logic sel, last_grant, ar, br, pick_b, grant, timeout, done;
  logic [3:0] consec;
  logic [9:0] timer;
  // a read ack lands in IDLE while the requester still holds req; don't re-grant it
  assign ar = a_req & ~a_ack;
  assign br = b_req & ~b_ack;
  assign grant = (state == IDLE) && !ctl_busy && (ar || br);
  assign timeout = timer == 10'(RD_TIMEOUT - 1);
  assign done = ctl_out_valid || timeout;
  always_comb begin
    pick_b = (ar && br) ? ((PRIO_A != 0) ? (consec == 4'(STARVE_MAX)) : !last_grant) : br;
    state_n = state;
    case (state)
      IDLE:    state_n = grant ? ISSUE : IDLE;
      ISSUE:   state_n = ctl_rw ? SETTLE : WAIT_RD;
      SETTLE:  state_n = IDLE;
      WAIT_RD: state_n = done ? IDLE : WAIT_RD;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      sel <= 1'b0;
      last_grant <= 1'b1;
      consec <= '0;
      timer <= '0;
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
      ctl_in_valid <= 1'b0;
      ctl_rw <= 1'b0;
      ctl_addr <= '0;
      ctl_wdata <= '0;
      err_timeout <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      ctl_in_valid <= 1'b0;
      if (grant) begin
        sel <= pick_b;
        last_grant <= pick_b;
        consec <= (pick_b || !br) ? '0 : (consec == 4'(STARVE_MAX)) ? consec : consec + 4'd1;
        ctl_in_valid <= 1'b1;
        ctl_rw <= pick_b ? b_rw : a_rw;
        ctl_addr <= pick_b ? b_addr : a_addr;
        ctl_wdata <= pick_b ? b_wdata : a_wdata;
        a_ack <= !pick_b && a_rw;
        b_ack <= pick_b && b_rw;
      end
      if (state == ISSUE) timer <= '0;
      if (state == WAIT_RD) begin
        timer <= timer + 10'd1;
        if (done) begin
          a_ack <= !sel;
          b_ack <= sel;
          if (!sel) a_rdata <= ctl_out_valid ? ctl_rdata : DATA_W'(32'hDEAD_BEEF);
          if (sel) b_rdata <= ctl_out_valid ? ctl_rdata : DATA_W'(32'hDEAD_BEEF);
          if (!ctl_out_valid) err_timeout <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sdram_req_arbiter.sv
// tb_sdram_req_arbiter: directed bench with a round-robin and an A-priority instance
// driven by the same stimulus.
module tb_sdram_req_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic a_req = 0, a_rw = 0, b_req = 0, b_rw = 0;
  logic [22:0] a_addr = '0, b_addr = '0;
  logic [31:0] a_wdata = '0, b_wdata = '0, ctl_rdata = '0;
  logic ctl_busy = 0, ctl_out_valid = 0;
  logic r_a_ack, r_b_ack, r_civ, r_crw, r_err, p_a_ack, p_b_ack, p_civ, p_crw, p_err;
  logic [31:0] r_a_rdata, r_b_rdata, r_cwdata, p_a_rdata, p_b_rdata, p_cwdata;
  logic [22:0] r_caddr, p_caddr;
  int n_asrt = 0, n_fail = 0, cnt;
  bit exp_a;
  always #5 clk = ~clk;
  sdram_req_arbiter #(.PRIO_A(0), .STARVE_MAX(4), .RD_TIMEOUT(8)) dut_rr (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_rw(a_rw), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(r_a_ack), .a_rdata(r_a_rdata),
    .b_req(b_req), .b_rw(b_rw), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(r_b_ack), .b_rdata(r_b_rdata),
    .ctl_in_valid(r_civ), .ctl_rw(r_crw), .ctl_addr(r_caddr), .ctl_wdata(r_cwdata),
    .ctl_busy(ctl_busy), .ctl_out_valid(ctl_out_valid), .ctl_rdata(ctl_rdata), .err_timeout(r_err));
  sdram_req_arbiter #(.PRIO_A(1), .STARVE_MAX(4), .RD_TIMEOUT(8)) dut_pa (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_rw(a_rw), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(p_a_ack), .a_rdata(p_a_rdata),
    .b_req(b_req), .b_rw(b_rw), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(p_b_ack), .b_rdata(p_b_rdata),
    .ctl_in_valid(p_civ), .ctl_rw(p_crw), .ctl_addr(p_caddr), .ctl_wdata(p_cwdata),
    .ctl_busy(ctl_busy), .ctl_out_valid(ctl_out_valid), .ctl_rdata(ctl_rdata), .err_timeout(p_err));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    step();
    step();
    chk("rst_civ", 32'(r_civ), 0);
    chk("rst_a_ack", 32'(r_a_ack), 0);
    chk("rst_err", 32'(r_err), 0);
    chk("rst_addr", 32'(r_caddr), 0);
    rst = 0;
    // single write from A
    a_req = 1; a_rw = 1; a_addr = 23'h000400; a_wdata = 32'h1234_5678;
    step();
    chk("wr_civ", 32'(r_civ), 1);
    chk("wr_rw", 32'(r_crw), 1);
    chk("wr_addr", 32'(r_caddr), 32'h400);
    chk("wr_wdata", r_cwdata, 32'h1234_5678);
    chk("wr_a_ack", 32'(r_a_ack), 1);
    chk("wr_b_ack", 32'(r_b_ack), 0);
    a_req = 0;
    step();
    chk("wr_civ_drop", 32'(r_civ), 0);
    chk("wr_ack_drop", 32'(r_a_ack), 0);
    step();
    // read from B, data returned 5 cycles after in_valid
    b_req = 1; b_rw = 0; b_addr = 23'h000010;
    step();
    chk("rd_civ", 32'(r_civ), 1);
    chk("rd_rw", 32'(r_crw), 0);
    chk("rd_addr", 32'(r_caddr), 32'h10);
    chk("rd_no_early_ack", 32'(r_b_ack), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rd_wait_b_ack", 32'(r_b_ack | r_a_ack | r_civ), 0);
    end
    step();
    ctl_out_valid = 1; ctl_rdata = 32'hCAFE_0001;
    step();
    ctl_out_valid = 0;
    chk("rd_b_ack", 32'(r_b_ack), 1);
    chk("rd_b_rdata", r_b_rdata, 32'hCAFE_0001);
    chk("rd_a_ack", 32'(r_a_ack), 0);
    chk("rd_a_rdata", r_a_rdata, 0);
    b_req = 0;
    step();
    chk("rd_b_ack_drop", 32'(r_b_ack), 0);
    // both requesting writes; no issue while busy
    ctl_busy = 1;
    a_req = 1; a_rw = 1; a_addr = 23'h000100; a_wdata = 32'hA0;
    b_req = 1; b_rw = 1; b_addr = 23'h000200; b_wdata = 32'hB0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("busy_hold_rr", 32'(r_civ), 0);
      chk("busy_hold_pa", 32'(p_civ), 0);
    end
    ctl_busy = 0;
    for (int op = 0; op < 10; op++) begin
      cnt = 0;
      step();
      cnt++;
      while (!r_civ && cnt < 8) begin
        step();
        cnt++;
      end
      chk("arb_issue", 32'(r_civ), 1);
      if (op > 0) chk("arb_spacing", cnt, 3);
      exp_a = (op % 2) == 0;
      chk("rr_a_ack", 32'(r_a_ack), 32'(exp_a));
      chk("rr_b_ack", 32'(r_b_ack), 32'(!exp_a));
      chk("rr_addr", 32'(r_caddr), exp_a ? 32'h100 : 32'h200);
      exp_a = (op % 5) != 4;
      chk("pa_a_ack", 32'(p_a_ack), 32'(exp_a));
      chk("pa_b_ack", 32'(p_b_ack), 32'(!exp_a));
      chk("pa_wdata", p_cwdata, exp_a ? 32'hA0 : 32'hB0);
    end
    a_req = 0; b_req = 0;
    step();
    step();
    // read timeout: no out_valid ever
    a_req = 1; a_rw = 0; a_addr = 23'h000020;
    step();
    chk("to_civ", 32'(r_civ), 1);
    cnt = 0;
    while (!r_a_ack && cnt < 20) begin
      step();
      cnt++;
    end
    chk("to_latency", cnt, 9);
    chk("to_rdata", r_a_rdata, 32'hDEAD_BEEF);
    chk("to_err", 32'(r_err), 1);
    chk("to_b_ack", 32'(r_b_ack), 0);
    a_req = 0;
    step();
    chk("to_ack_drop", 32'(r_a_ack), 0);
    ctl_out_valid = 1; ctl_rdata = 32'h1111;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("spur_no_ack", 32'(r_a_ack | r_b_ack), 0);
      chk("spur_err_held", 32'(r_err), 1);
      chk("spur_rdata", r_a_rdata, 32'hDEAD_BEEF);
    end
    ctl_out_valid = 0;
    // reset during a read
    b_req = 1; b_rw = 0; b_addr = 23'h000030;
    step();
    chk("rr_rd_civ", 32'(r_civ), 1);
    step();
    step();
    rst = 1;
    step();
    chk("mrst_civ", 32'(r_civ), 0);
    chk("mrst_addr", 32'(r_caddr), 0);
    chk("mrst_b_ack", 32'(r_b_ack), 0);
    chk("mrst_b_rdata", r_b_rdata, 0);
    chk("mrst_a_rdata", r_a_rdata, 0);
    chk("mrst_err", 32'(r_err), 0);
    rst = 0; b_req = 0;
    ctl_out_valid = 1; ctl_rdata = 32'h2222;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mrst_no_ack", 32'(r_a_ack | r_b_ack), 0);
    end
    ctl_out_valid = 0;
    a_req = 1; a_rw = 1; a_addr = 23'h000055; a_wdata = 32'h77;
    step();
    chk("post_wr_civ", 32'(r_civ), 1);
    chk("post_wr_ack", 32'(r_a_ack), 1);
    chk("post_wr_addr", 32'(r_caddr), 32'h55);
    a_req = 0;
    step();
    step();
    a_req = 1; a_rw = 0; a_addr = 23'h000066;
    step();
    chk("post_rd_civ", 32'(r_civ), 1);
    step();
    ctl_out_valid = 1; ctl_rdata = 32'h0000_0012;
    step();
    ctl_out_valid = 0;
    chk("post_rd_ack", 32'(r_a_ack), 1);
    chk("post_rd_rdata", r_a_rdata, 32'h12);
    chk("post_rd_err", 32'(r_err), 0);
    a_req = 0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
